// File: rtl/board_pkg.sv
// Shared board geometry, token encoding and turn-sequencer state set for the
// 7x6 board storage and the logic that drives it.
package board_pkg;

   localparam int COLS     = 7;
   localparam int ROWS     = 6;
   localparam int COL_W    = 3;
   localparam int HEIGHT_W = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } token_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_MOVE,
      S_COMMIT,
      S_SETTLE,
      S_DONE
   } state_t;

   function automatic token_t other_player(input token_t t);
      return (t == P1) ? P2 : P1;
   endfunction

endpackage

// File: rtl/column_heights.sv
// Per-column fill counters for the board: saturating at ROWS, globally
// clearable, with a full vector and the lowest-index column still open.
module column_heights
   import board_pkg::*;
#(
   parameter int COLS = board_pkg::COLS,
   parameter int ROWS = board_pkg::ROWS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     inc,
   input  logic [COL_W-1:0]         inc_col,
   output logic [COLS-1:0]          full,
   output logic [COL_W-1:0]         lowest_free,
   output logic                     any_free
);

   logic [HEIGHT_W-1:0] height_q [COLS];
   logic [HEIGHT_W-1:0] height_d [COLS];

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         height_d[c] = height_q[c];
         if (clr) begin
            height_d[c] = '0;
         end else if (inc && (inc_col == COL_W'(c)) &&
                      (height_q[c] != HEIGHT_W'(ROWS))) begin
            height_d[c] = height_q[c] + HEIGHT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < COLS; c++) begin
         if (rst) begin
            height_q[c] <= '0;
         end else begin
            height_q[c] <= height_d[c];
         end
      end
   end

   // Scan from the top index down so the lowest open column wins.
   always_comb begin
      full        = '0;
      lowest_free = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         full[c] = (height_q[c] == HEIGHT_W'(ROWS));
         if (!full[c]) begin
            lowest_free = COL_W'(c);
         end
      end
      any_free = ~&full;
   end

endmodule

// File: rtl/move_controller.sv
// Turn sequencer for the board storage: validates column requests, issues
// single-cycle load commands, handles turn timeout, win and draw.
module move_controller
   import board_pkg::*;
#(
   parameter int COLS           = board_pkg::COLS,
   parameter int ROWS           = board_pkg::ROWS,
   parameter int TIMEOUT_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_valid,
   input  logic [2:0] move_col,
   input  logic       win_in,
   output logic       move_ready,
   output logic       load,
   output logic [2:0] column,
   output logic [1:0] mux_out,
   output logic [1:0] turn,
   output logic       board_clr,
   output logic       illegal,
   output logic       auto_move,
   output logic [1:0] winner,
   output logic       draw,
   output logic       busy
);

   localparam logic [5:0]  CELLS        = 6'(COLS * ROWS);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t           state_q,   state_d;
   token_t           turn_q,    turn_d;
   token_t           winner_q,  winner_d;
   logic [COL_W-1:0] col_q,     col_d;
   logic             auto_q,    auto_d;
   logic             illegal_q, illegal_d;
   logic             draw_q,    draw_d;
   logic [31:0]      timer_q,   timer_d;
   logic [5:0]       count_q,   count_d;

   logic [COLS-1:0]  full;
   logic [COL_W-1:0] lowest_free;
   logic             any_free;
   logic [7:0]       full_pad;
   logic             req_legal;

   column_heights #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_heights (
      .clk         (clk),
      .rst         (rst),
      .clr         (state_q == S_CLEAR),
      .inc         (state_q == S_COMMIT),
      .inc_col     (col_q),
      .full        (full),
      .lowest_free (lowest_free),
      .any_free    (any_free)
   );

   // Columns past COLS read as full, which folds the range check into one lookup.
   always_comb begin
      full_pad             = '1;
      full_pad[COLS-1:0]   = full;
      req_legal            = move_valid && !full_pad[move_col];
   end

   always_comb begin
      state_d   = state_q;
      turn_d    = turn_q;
      winner_d  = winner_q;
      col_d     = col_q;
      auto_d    = 1'b0;
      illegal_d = 1'b0;
      draw_d    = draw_q;
      timer_d   = timer_q;
      count_d   = count_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            winner_d = EMPTY;
            draw_d   = 1'b0;
            timer_d  = '0;
            count_d  = '0;
            turn_d   = P1;
            state_d  = S_WAIT_MOVE;
         end
         S_WAIT_MOVE: begin
            if (req_legal) begin
               col_d   = move_col;
               timer_d = '0;
               state_d = S_COMMIT;
            end else if ((timer_q == TIMEOUT_LAST) && any_free) begin
               col_d     = lowest_free;
               timer_d   = '0;
               auto_d    = 1'b1;
               illegal_d = move_valid;
               state_d   = S_COMMIT;
            end else if (move_valid) begin
               illegal_d = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_COMMIT: begin
            count_d = count_q + 6'd1;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (win_in) begin
               winner_d = turn_q;
               turn_d   = EMPTY;
               state_d  = S_DONE;
            end else if (count_q == CELLS) begin
               draw_d  = 1'b1;
               turn_d  = EMPTY;
               state_d = S_DONE;
            end else begin
               turn_d  = other_player(turn_q);
               state_d = S_WAIT_MOVE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         turn_q    <= EMPTY;
         winner_q  <= EMPTY;
         col_q     <= '0;
         auto_q    <= 1'b0;
         illegal_q <= 1'b0;
         draw_q    <= 1'b0;
         timer_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         turn_q    <= turn_d;
         winner_q  <= winner_d;
         col_q     <= col_d;
         auto_q    <= auto_d;
         illegal_q <= illegal_d;
         draw_q    <= draw_d;
         timer_q   <= timer_d;
         count_q   <= count_d;
      end
   end

   // auto_q is only ever set on entry to COMMIT, so it lines up with load.
   always_comb begin
      move_ready = (state_q == S_WAIT_MOVE);
      load       = (state_q == S_COMMIT);
      column     = load ? col_q : 3'd0;
      mux_out    = load ? turn_q : EMPTY;
      turn       = turn_q;
      board_clr  = (state_q == S_CLEAR);
      illegal    = illegal_q;
      auto_move  = auto_q;
      winner     = winner_q;
      draw       = draw_q;
      busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: scoreboard of expected load commands
// plus step-by-step checks of turn, illegal, timeout, win and draw behaviour.
module tb_move_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic       move_valid;
   logic [2:0] move_col;
   logic       win_in;
   logic       move_ready;
   logic       load;
   logic [2:0] column;
   logic [1:0] mux_out;
   logic [1:0] turn;
   logic       board_clr;
   logic       illegal;
   logic       auto_move;
   logic [1:0] winner;
   logic       draw;
   logic       busy;

   int n_cmp;
   int n_err;

   logic [5:0] exp_q[$];

   logic [1:0] exp_turn;
   logic [1:0] exp_winner;
   logic       exp_draw;
   int         exp_count;
   int         ht[7];

   logic prev_load, prev_clr, prev_ill, prev_auto;

   move_controller #(
      .COLS           (7),
      .ROWS           (6),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .move_valid (move_valid),
      .move_col   (move_col),
      .win_in     (win_in),
      .move_ready (move_ready),
      .load       (load),
      .column     (column),
      .mux_out    (mux_out),
      .turn       (turn),
      .board_clr  (board_clr),
      .illegal    (illegal),
      .auto_move  (auto_move),
      .winner     (winner),
      .draw       (draw),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every load must match the oldest expected command.
   always @(negedge clk) begin
      if (load) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_load observed=%0h expected=none", {auto_move, column, mux_out});
         end else begin
            check("load_cmd", {26'd0, auto_move, column, mux_out}, {26'd0, exp_q.pop_front()});
         end
         check("load_no_repeat", prev_load, 0);
      end
      if (board_clr) check("clr_no_repeat", prev_clr, 0);
      if (illegal)   check("illegal_no_repeat", prev_ill, 0);
      if (auto_move) check("auto_no_repeat", prev_auto, 0);
      prev_load = load;
      prev_clr  = board_clr;
      prev_ill  = illegal;
      prev_auto = auto_move;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"},
            {20'd0, move_ready, load, column, mux_out, turn, board_clr, illegal, auto_move,
             winner, draw, busy},
            32'd0);
   endtask

   task automatic model_new_game();
      exp_turn   = 2'b01;
      exp_winner = 2'b00;
      exp_draw   = 1'b0;
      exp_count  = 0;
      for (int c = 0; c < 7; c++) ht[c] = 0;
   endtask

   task automatic model_settle(input logic [2:0] col, input logic win);
      ht[col]++;
      exp_count++;
      if (win) begin
         exp_winner = exp_turn;
         exp_turn   = 2'b00;
      end else if (exp_count == 42) begin
         exp_draw = 1'b1;
         exp_turn = 2'b00;
      end else begin
         exp_turn = (exp_turn == 2'b01) ? 2'b10 : 2'b01;
      end
   endtask

   // Called in the first WAIT_MOVE cycle; returns in the cycle after SETTLE.
   task automatic play(input logic [2:0] col, input logic win);
      check("ready_before_move", move_ready, 1);
      move_valid = 1'b1;
      move_col   = col;
      exp_q.push_back({1'b0, col, exp_turn});
      tick();
      move_valid = 1'b0;
      move_col   = 3'd0;
      check("load_in_commit", load, 1);
      tick();
      win_in = win;
      tick();
      win_in = 1'b0;
      model_settle(col, win);
      check("turn_after_settle", turn, exp_turn);
   endtask

   task automatic start_game();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clr_pulse", board_clr, 1);
      tick();
      model_new_game();
      check("clr_done", board_clr, 0);
      check("turn_after_clear", turn, exp_turn);
      check("winner_after_clear", winner, 0);
      check("draw_after_clear", draw, 0);
   endtask

   initial begin
      logic [2:0] auto_col;
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      start      = 1'b0;
      move_valid = 1'b0;
      move_col   = 3'd0;
      win_in     = 1'b0;
      prev_load  = 1'b0;
      prev_clr   = 1'b0;
      prev_ill   = 1'b0;
      prev_auto  = 1'b0;
      model_new_game();
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check_all_zero("idle");

      // First game: opening move into column 3.
      start_game();
      check("busy_in_game", busy, 1);
      play(3'd3, 1'b0);
      check("p2_turn", turn, 2'b10);

      // start during a game is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ignored_clr", board_clr, 0);
      check("start_ignored_ready", move_ready, 1);

      for (int i = 0; i < 6; i++) play(3'd0, 1'b0);

      // Seventh request into full column 0.
      move_valid = 1'b1;
      move_col   = 3'd0;
      tick();
      move_valid = 1'b0;
      check("full_col_illegal", illegal, 1);
      check("full_col_no_load", load, 0);
      check("full_col_turn", turn, exp_turn);
      check("full_col_ready", move_ready, 1);
      tick();
      check("full_col_illegal_drop", illegal, 0);

      // Out-of-range column.
      move_valid = 1'b1;
      move_col   = 3'd7;
      tick();
      move_valid = 1'b0;
      move_col   = 3'd0;
      check("col7_illegal", illegal, 1);
      check("col7_ready", move_ready, 1);
      check("col7_turn", turn, exp_turn);
      tick();
      check("col7_illegal_drop", illegal, 0);

      for (int i = 0; i < 6; i++) play(3'd1, 1'b0);

      // Timeout: 16 idle WAIT_MOVE cycles, then an auto move to lowest open column.
      auto_col = 3'd0;
      for (int c = 6; c >= 0; c--) if (ht[c] < 6) auto_col = 3'(c);
      repeat (15) tick();
      check("pre_timeout_ready", move_ready, 1);
      check("pre_timeout_no_load", load, 0);
      exp_q.push_back({1'b1, auto_col, exp_turn});
      tick();
      check("timeout_auto", auto_move, 1);
      check("timeout_load", load, 1);
      check("timeout_col", column, 3'd2);
      tick();
      tick();
      model_settle(auto_col, 1'b0);
      check("turn_after_auto", turn, exp_turn);

      // Win on a P2 move.
      if (exp_turn != 2'b10) play(3'd3, 1'b0);
      play(3'd4, 1'b1);
      check("win_winner", winner, 2'b10);
      check("win_turn", turn, 2'b00);
      check("win_busy", busy, 0);
      move_valid = 1'b1;
      move_col   = 3'd5;
      repeat (3) tick();
      move_valid = 1'b0;
      check("done_no_ready", move_ready, 0);
      check("done_winner_hold", winner, exp_winner);
      check("done_no_illegal", illegal, 0);

      // Second game: fill the board with no winner.
      start_game();
      for (int i = 0; i < 42; i++) play(3'(i % 7), 1'b0);
      check("draw_flag", draw, exp_draw);
      check("draw_turn", turn, 2'b00);
      check("draw_winner", winner, 2'b00);
      check("draw_busy", busy, 0);
      start_game();
      check("draw_cleared", draw, 0);

      // Reset while in COMMIT.
      move_valid = 1'b1;
      move_col   = 3'd5;
      exp_q.push_back({1'b0, 3'd5, exp_turn});
      tick();
      move_valid = 1'b0;
      check("pre_reset_load", load, 1);
      rst = 1'b1;
      tick();
      check_all_zero("mid_commit_reset");
      rst = 1'b0;
      tick();
      check_all_zero("after_reset");

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
